// File: rtl/vga_timing_gen_if.sv
// Pixel-scan interface between the VGA raster source and the sprite renderers.
// The raster is a free-running stream: there is no valid/ready pair and no
// backpressure. Every field except vga_clk is updated together on the Clk
// edge where vga_clk falls. All fields therefore describe the same pixel, and
// consumers may sample them on the vga_clk rising edge.
interface vga_timing_gen_if;
   logic       vga_clk;
   logic       hs;
   logic       vs;
   logic       blank;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       frame_start;
   logic       sec_tick;

   // Raster source side
   modport master (
      output vga_clk, hs, vs, blank, DrawX, DrawY, frame_start, sec_tick
   );

   // Renderer side
   modport slave (
      input vga_clk, hs, vs, blank, DrawX, DrawY, frame_start, sec_tick
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from a 50 MHz system clock.
// Divides Clk by two into the pixel clock vga_clk. It scans DrawX/DrawY and
// emits hs, vs, blank and frame_start, all registered with the coordinate
// they describe.
// Optional feature macro: FRAME_TICK_EN. When it is defined, a frame counter
// pulses sec_tick once every TICK_FRAMES frames. When it is undefined,
// sec_tick is tied low and no counter is built.
module vga_timing_gen #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int TICK_FRAMES = 60
) (
   input  logic             Clk,
   input  logic             Reset,
   vga_timing_gen_if.master vga_o
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Boundaries are sized to the 10-bit coordinate.
   // All compares run at full counter width.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic       vga_clk_q, vga_clk_d;
   logic       pix_adv;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       frame_start_q, frame_start_d;

   // Pixel clock: toggle every Clk; the first edge after reset drives 1.
   always_comb begin
      vga_clk_d = ~vga_clk_q;
   end

   // Pixel clock register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vga_clk_q <= 1'b0;
      end else begin
         vga_clk_q <= vga_clk_d;
      end
   end

   // The raster advances on the Clk edge that takes vga_clk from 1 to 0.
   // Outputs are therefore settled a full Clk before vga_clk rises.
   assign pix_adv = vga_clk_q;

   // Next coordinate: step X each pixel period; wrap X into a Y step and wrap Y
   // at the end of the frame.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_adv) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
               y_d = '0;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   // Decode the flags from the coordinate being loaded.
   // Flags and coordinate are then registered together with zero skew.
   always_comb begin
      hs_d          = ~((x_d >= HS_START) && (x_d < HS_END));
      vs_d          = ~((y_d >= VS_START) && (y_d < VS_END));
      blank_d       = (x_d < H_VIS) && (y_d < V_VIS);
      frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
   end

   // Raster state: coordinate plus its decoded flags.
   // Reset restarts the scan at (0,0).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q           <= '0;
         y_q           <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_q       <= 1'b1;
         frame_start_q <= 1'b1;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef FRAME_TICK_EN
   localparam logic [5:0] TICK_LAST = 6'(TICK_FRAMES - 1);

   logic [5:0] frame_cnt_q, frame_cnt_d;
   logic       sec_tick_q, sec_tick_d;

   // Count generated frame starts. The reset-time frame_start is frame 0 and
   // is not counted. The tick fires with the frame_start that wraps the count.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      sec_tick_d  = sec_tick_q;
      if (pix_adv) begin
         sec_tick_d = 1'b0;
         if (frame_start_d) begin
            if (frame_cnt_q == TICK_LAST) begin
               frame_cnt_d = '0;
               sec_tick_d  = 1'b1;
            end else begin
               frame_cnt_d = frame_cnt_q + 6'd1;
            end
         end
      end
   end

   // Frame counter and tick registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_cnt_q <= '0;
         sec_tick_q  <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         sec_tick_q  <= sec_tick_d;
      end
   end

   assign vga_o.sec_tick = sec_tick_q;
`else
   assign vga_o.sec_tick = 1'b0;
`endif

   assign vga_o.vga_clk     = vga_clk_q;
   assign vga_o.DrawX       = x_q;
   assign vga_o.DrawY       = y_q;
   assign vga_o.hs          = hs_q;
   assign vga_o.vs          = vs_q;
   assign vga_o.blank       = blank_q;
   assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen.
// Keeps the horizontal timing at 640x480 values. Shrinks the vertical timing
// to 4/1/2/1 lines (8 lines per frame) so that several whole frames fit in a
// short run. With FRAME_TICK_EN, sec_tick is expected every 2 frames.
module tb_vga_timing_gen;

   localparam int LINE_PIX  = 800;
   localparam int FRAME_PIX = 800 * 8;
   localparam int RUN_CYC   = 4 * 2 * FRAME_PIX + 400;

   logic Clk;
   logic Reset;
   int   n_total;
   int   n_bad;

   vga_timing_gen_if vif();

   vga_timing_gen #(
      .V_VISIBLE   (4),
      .V_FRONT     (1),
      .V_SYNC      (2),
      .V_BACK      (1),
      .TICK_FRAMES (2)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .vga_o (vif)
   );

   // Clock: 10 ns Clk period
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pack of every DUT output: {6'b0, x, y, vga_clk, hs, vs, blank, fs, tick}
   function automatic logic [31:0] dut_vec();
      return {6'b0, vif.DrawX, vif.DrawY, vif.vga_clk, vif.hs, vif.vs,
              vif.blank, vif.frame_start, vif.sec_tick};
   endfunction

   // Expected outputs after Clk edge c (c=1 is the first edge after release).
   function automatic logic [31:0] exp_vec(input int c);
      int         p, f;
      logic [9:0] ex, ey;
      logic       e_vga, e_hs, e_vs, e_blank, e_fs, e_tick;
      p       = c / 2;
      f       = p / FRAME_PIX;
      ex      = 10'(p % LINE_PIX);
      ey      = 10'((p / LINE_PIX) % 8);
      e_vga   = (c % 2) == 1;
      e_hs    = !(ex >= 10'd656 && ex <= 10'd751);
      e_vs    = !(ey >= 10'd5 && ey <= 10'd6);
      e_blank = (ex < 10'd640) && (ey < 10'd4);
      e_fs    = (ex == 10'd0) && (ey == 10'd0);
`ifdef FRAME_TICK_EN
      e_tick  = e_fs && (f > 0) && ((f % 2) == 0);
`else
      e_tick  = 1'b0;
`endif
      return {6'b0, ex, ey, e_vga, e_hs, e_vs, e_blank, e_fs, e_tick};
   endfunction

   initial begin
      logic [31:0] prev_stable;
      logic        fs_prev;
      int          p;
      int          hs_low, hs_first, hs_last, blank_fall;
      int          vs_pix, vs_first, vs_last, porch_blank;
      int          tick_cnt, n_rise;
      int          fs_rise [2];
      bit          found;

      n_total    = 0;
      n_bad      = 0;
      hs_low     = 0;
      hs_first   = -1;
      hs_last    = -1;
      blank_fall = -1;
      vs_pix     = 0;
      vs_first   = -1;
      vs_last    = -1;
      porch_blank = 0;
      tick_cnt   = 0;
      n_rise     = 0;
      fs_rise[0] = -1;
      fs_rise[1] = -1;

      // Reset for 3 Clk
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_vga_clk", 32'(vif.vga_clk), 32'd0);
      check("rst_x", 32'(vif.DrawX), 32'd0);
      check("rst_y", 32'(vif.DrawY), 32'd0);
      check("rst_hs", 32'(vif.hs), 32'd1);
      check("rst_vs", 32'(vif.vs), 32'd1);
      check("rst_blank", 32'(vif.blank), 32'd1);
      check("rst_fs", 32'(vif.frame_start), 32'd1);
      check("rst_tick", 32'(vif.sec_tick), 32'd0);
      prev_stable = {9'b0, vif.DrawX, vif.DrawY, vif.hs, vif.vs, vif.blank};
      fs_prev     = vif.frame_start;
      Reset = 1'b0;

      // Free run over four frames plus a little
      for (int c = 1; c <= RUN_CYC; c++) begin
         @(negedge Clk);
         check("scan", dut_vec(), exp_vec(c));
         if (c <= 4) check("vga_clk_seq", 32'(vif.vga_clk), 32'(c % 2));
         if (c == 1) check("hold_x", 32'(vif.DrawX), 32'd0);
         if (c == 2) check("step_x", 32'(vif.DrawX), 32'd1);
         if (vif.frame_start && !fs_prev && n_rise < 2) begin
            fs_rise[n_rise] = c;
            n_rise++;
         end
         fs_prev = vif.frame_start;
         if ((c % 2) == 1) begin
            // vga_clk rose on this edge: the raster must not have moved
            check("rise_stable",
                  {9'b0, vif.DrawX, vif.DrawY, vif.hs, vif.vs, vif.blank}, prev_stable);
            p = (c - 1) / 2;
            if (p < LINE_PIX) begin
               if (!vif.hs) begin
                  hs_low++;
                  if (hs_first < 0) hs_first = int'(vif.DrawX);
                  hs_last = int'(vif.DrawX);
               end
               if (!vif.blank && blank_fall < 0) blank_fall = int'(vif.DrawX);
            end
            if (p == LINE_PIX - 1) begin
               check("line_end_x", 32'(vif.DrawX), 32'd799);
               check("line_end_y", 32'(vif.DrawY), 32'd0);
            end
            if (p == LINE_PIX) begin
               check("wrap_x", 32'(vif.DrawX), 32'd0);
               check("wrap_y", 32'(vif.DrawY), 32'd1);
            end
            if (p < FRAME_PIX) begin
               if (!vif.vs) begin
                  vs_pix++;
                  if (vs_first < 0) vs_first = int'(vif.DrawY);
                  vs_last = int'(vif.DrawY);
               end
               if (vif.DrawY >= 10'd4 && vif.blank) porch_blank++;
            end
            if (vif.sec_tick) tick_cnt++;
         end
         prev_stable = {9'b0, vif.DrawX, vif.DrawY, vif.hs, vif.vs, vif.blank};
      end

      check("hs_low_pixels", 32'(hs_low), 32'd96);
      check("hs_first_x", 32'(hs_first), 32'd656);
      check("hs_last_x", 32'(hs_last), 32'd751);
      check("blank_fall_x", 32'(blank_fall), 32'd640);
      check("vs_low_pixels", 32'(vs_pix), 32'd1600);
      check("vs_first_y", 32'(vs_first), 32'd5);
      check("vs_last_y", 32'(vs_last), 32'd6);
      check("porch_blank", 32'(porch_blank), 32'd0);
      check("fs_rise_1", 32'(fs_rise[0]), 32'd12800);
      check("fs_rise_2", 32'(fs_rise[1]), 32'd25600);
`ifdef FRAME_TICK_EN
      check("tick_count", 32'(tick_cnt), 32'd2);
`else
      check("tick_count", 32'(tick_cnt), 32'd0);
`endif

      // Mid-frame reset at (300,2), bounded search
      found = 1'b0;
      for (int k = 0; k < 14000 && !found; k++) begin
         @(negedge Clk);
         if (vif.DrawX == 10'd300 && vif.DrawY == 10'd2) found = 1'b1;
      end
      check("mid_rst_found", 32'(found), 32'd1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("mid_rst_x", 32'(vif.DrawX), 32'd0);
      check("mid_rst_y", 32'(vif.DrawY), 32'd0);
      check("mid_rst_vga_clk", 32'(vif.vga_clk), 32'd0);
      check("mid_rst_hs", 32'(vif.hs), 32'd1);
      check("mid_rst_vs", 32'(vif.vs), 32'd1);
      check("mid_rst_blank", 32'(vif.blank), 32'd1);
      check("mid_rst_fs", 32'(vif.frame_start), 32'd1);
      @(negedge Clk);
      check("post_rst_vga_clk", 32'(vif.vga_clk), 32'd1);
      check("post_rst_x_hold", 32'(vif.DrawX), 32'd0);
      @(negedge Clk);
      check("post_rst_vga_clk_2", 32'(vif.vga_clk), 32'd0);
      check("post_rst_x_step", 32'(vif.DrawX), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
